aes_inv_key_schedule: RTL and testbench

AES_INV_KEY_SCHEDULE -- requirements
Module: aes_inv_key_schedule

---
 rtl/aes_inv_key_schedule.sv | 217 +++++++++++++++++++++
 tb/tb_aes_inv_key_schedule.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_key_schedule.sv
// AES-128 key schedule that expands a cipher key forward, then streams round keys 10..0 back out.
// Optional build macro AES_EQ_INV_CIPHER_EN: rounds 9..1 are emitted through InvMixColumns.

module aes_sbox (
   input  logic [7:0] a,
   output logic [7:0] s
);

   // GF(2^8) multiply, reduction polynomial x^8+x^4+x^3+x+1
   function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
      logic [7:0] p;
      logic [7:0] t;
      p = 8'h00;
      t = x;
      for (int i = 0; i < 8; i++) begin
         if (y[i]) p = p ^ t;
         t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   logic [7:0] x2, x3, x6, x12, x14, x15, x30, x60, x120, x240, inv;

   // Multiplicative inverse as a^254 (maps 0 to 0), then the standard affine transform
   assign x2   = gmul(a, a);
   assign x3   = gmul(x2, a);
   assign x6   = gmul(x3, x3);
   assign x12  = gmul(x6, x6);
   assign x14  = gmul(x12, x2);
   assign x15  = gmul(x12, x3);
   assign x30  = gmul(x15, x15);
   assign x60  = gmul(x30, x30);
   assign x120 = gmul(x60, x60);
   assign x240 = gmul(x120, x120);
   assign inv  = gmul(x240, x14);

   assign s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
              {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;

endmodule

module aes_inv_key_schedule (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] key,
   output logic         busy,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic [127:0] rk_data,
   output logic [3:0]   rk_round,
   output logic         rk_last
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EXPAND = 2'd1,
      OUTPUT = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [127:0]  rk_q, rk_d;
   logic [3:0]    round_q, round_d;

   logic [31:0]   w0, w1, w2, w3;
   logic [31:0]   sub_in, rot, sub_out;
   logic [3:0]    rcon_idx;
   logic [7:0]    rcon;
   logic [127:0]  fwd_key, inv_key;

   function automatic logic [7:0] rcon_lookup(input logic [3:0] idx);
      case (idx)
         4'd0:    return 8'h01;
         4'd1:    return 8'h02;
         4'd2:    return 8'h04;
         4'd3:    return 8'h08;
         4'd4:    return 8'h10;
         4'd5:    return 8'h20;
         4'd6:    return 8'h40;
         4'd7:    return 8'h80;
         4'd8:    return 8'h1b;
         4'd9:    return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   assign w0 = rk_q[127:96];
   assign w1 = rk_q[95:64];
   assign w2 = rk_q[63:32];
   assign w3 = rk_q[31:0];

   // The inverse step needs the previous key's last word, recovered as W3^W2
   always_comb begin
      sub_in   = w3;
      rcon_idx = round_q;
      if (state_q == OUTPUT) begin
         sub_in   = w3 ^ w2;
         rcon_idx = round_q - 4'd1;
      end
   end

   assign rot  = {sub_in[23:0], sub_in[31:24]};
   assign rcon = rcon_lookup(rcon_idx);

   genvar b;
   generate
      for (b = 0; b < 4; b++) begin : g_sbox
         aes_sbox u_sbox (
            .a (rot[8*b +: 8]),
            .s (sub_out[8*b +: 8])
         );
      end
   endgenerate

   always_comb begin
      logic [31:0] f0, f1, f2, f3;
      logic [31:0] p0;
      f0 = w0 ^ sub_out ^ {rcon, 24'h000000};
      f1 = w1 ^ f0;
      f2 = w2 ^ f1;
      f3 = w3 ^ f2;
      p0 = w0 ^ sub_out ^ {rcon, 24'h000000};
      fwd_key = {f0, f1, f2, f3};
      inv_key = {p0, w1 ^ w0, w2 ^ w1, w3 ^ w2};
   end

   // Next-state logic: expand forward to round 10, then walk back one step per accepted beat
   always_comb begin
      state_d = state_q;
      rk_d    = rk_q;
      round_d = round_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               rk_d    = key;
               round_d = 4'd0;
               state_d = EXPAND;
            end
         end
         EXPAND: begin
            rk_d = fwd_key;
            if (round_q == 4'd9) begin
               round_d = 4'd10;
               state_d = OUTPUT;
            end else begin
               round_d = round_q + 4'd1;
            end
         end
         OUTPUT: begin
            if (rk_ready) begin
               if (round_q == 4'd0) begin
                  state_d = IDLE;
               end else begin
                  rk_d    = inv_key;
                  round_d = round_q - 4'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         rk_q    <= '0;
         round_q <= '0;
      end else begin
         state_q <= state_d;
         rk_q    <= rk_d;
         round_q <= round_d;
      end
   end

   assign busy     = (state_q != IDLE);
   assign rk_valid = (state_q == OUTPUT);
   assign rk_round = round_q;
   assign rk_last  = (state_q == OUTPUT) && (round_q == 4'd0);

`ifdef AES_EQ_INV_CIPHER_EN
   function automatic logic [7:0] xt(input logic [7:0] v);
      return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
      logic [7:0] a [4];
      logic [7:0] m2 [4];
      logic [7:0] m4 [4];
      logic [7:0] m8 [4];
      logic [7:0] m9 [4];
      logic [7:0] mb [4];
      logic [7:0] md [4];
      logic [7:0] me [4];
      for (int i = 0; i < 4; i++) begin
         a[i]  = c[31-8*i -: 8];
         m2[i] = xt(a[i]);
         m4[i] = xt(m2[i]);
         m8[i] = xt(m4[i]);
         m9[i] = m8[i] ^ a[i];
         mb[i] = m8[i] ^ m2[i] ^ a[i];
         md[i] = m8[i] ^ m4[i] ^ a[i];
         me[i] = m8[i] ^ m4[i] ^ m2[i];
      end
      return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
              m9[0] ^ me[1] ^ mb[2] ^ md[3],
              md[0] ^ m9[1] ^ me[2] ^ mb[3],
              mb[0] ^ md[1] ^ m9[2] ^ me[3]};
   endfunction

   // Equivalent inverse cipher wants the middle round keys pre-mixed; the register stays raw
   assign rk_data = (state_q == OUTPUT && round_q != 4'd0 && round_q != 4'd10) ?
                    {inv_mix_col(w0), inv_mix_col(w1), inv_mix_col(w2), inv_mix_col(w3)} : rk_q;
`else
   assign rk_data = rk_q;
`endif

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Directed bench for aes_inv_key_schedule using FIPS-197 round keys.

module tb_aes_inv_key_schedule;

   logic         clk;
   logic         rst;
   logic         start;
   logic [127:0] key;
   logic         busy;
   logic         rk_valid;
   logic         rk_ready;
   logic [127:0] rk_data;
   logic [3:0]   rk_round;
   logic         rk_last;

   int n_checks = 0;
   int n_fails  = 0;

   logic [127:0] fips_rk [0:10];
   logic [127:0] exp_rk  [0:10];

   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] SEQ_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] SEQ_R10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

   aes_inv_key_schedule dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .key      (key),
      .busy     (busy),
      .rk_valid (rk_valid),
      .rk_ready (rk_ready),
      .rk_data  (rk_data),
      .rk_round (rk_round),
      .rk_last  (rk_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef AES_EQ_INV_CIPHER_EN
   function automatic logic [7:0] tb_gmul(input logic [7:0] x, input logic [7:0] y);
      logic [7:0] p;
      logic [7:0] t;
      p = 8'h00;
      t = x;
      for (int i = 0; i < 8; i++) begin
         if (y[i]) p = p ^ t;
         t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [127:0] tb_inv_mix(input logic [127:0] v);
      logic [127:0] r;
      logic [7:0]   c [4];
      r = '0;
      for (int w = 0; w < 4; w++) begin
         for (int i = 0; i < 4; i++) c[i] = v[127-32*w-8*i -: 8];
         r[127-32*w -: 8]    = tb_gmul(c[0],8'h0e)^tb_gmul(c[1],8'h0b)^tb_gmul(c[2],8'h0d)^tb_gmul(c[3],8'h09);
         r[127-32*w-8 -: 8]  = tb_gmul(c[0],8'h09)^tb_gmul(c[1],8'h0e)^tb_gmul(c[2],8'h0b)^tb_gmul(c[3],8'h0d);
         r[127-32*w-16 -: 8] = tb_gmul(c[0],8'h0d)^tb_gmul(c[1],8'h09)^tb_gmul(c[2],8'h0e)^tb_gmul(c[3],8'h0b);
         r[127-32*w-24 -: 8] = tb_gmul(c[0],8'h0b)^tb_gmul(c[1],8'h0d)^tb_gmul(c[2],8'h09)^tb_gmul(c[3],8'h0e);
      end
      return r;
   endfunction
`endif

   function automatic logic [127:0] expv(input int r);
`ifdef AES_EQ_INV_CIPHER_EN
      if (r >= 1 && r <= 9) return tb_inv_mix(exp_rk[r]);
`endif
      return exp_rk[r];
   endfunction

   task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] want);
      n_checks++;
      if (got !== want) begin
         n_fails++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   task automatic checkZeros(input string tag);
      checkOutput({tag, "_busy"},     128'(busy),     128'd0);
      checkOutput({tag, "_valid"},    128'(rk_valid), 128'd0);
      checkOutput({tag, "_data"},     rk_data,        128'd0);
      checkOutput({tag, "_round"},    128'(rk_round), 128'd0);
      checkOutput({tag, "_last"},     128'(rk_last),  128'd0);
   endtask

   // Pulse start for one cycle; key is scrambled afterwards to prove it is only sampled with start
   task automatic applyStimulus(input logic [127:0] k);
      start = 1'b1;
      key   = k;
      @(posedge clk); #1;
      start = 1'b0;
      key   = ~k;
   endtask

   task automatic waitValid(input int already);
      int n;
      n = already;
      while (!rk_valid && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("latency", 128'(n), 128'd10);
   endtask

   // Consume the 11 beats; optional stalls, start pulse at one round, or reset at one round
   task automatic collectBeats(input logic [10:0] dmask, input bit stall, input int pulse_r, input int abort_r);
      for (int r = 10; r >= 0; r--) begin
         if (stall) begin
            int k;
            k = $urandom_range(1, 5);
            rk_ready = 1'b0;
            repeat (k) begin
               @(posedge clk); #1;
               checkOutput("stall_valid", 128'(rk_valid), 128'd1);
               checkOutput("stall_round", 128'(rk_round), 128'(r));
               if (dmask[r]) checkOutput("stall_data", rk_data, expv(r));
            end
            rk_ready = 1'b1;
         end
         if (r == abort_r) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            checkZeros("rst_output");
            return;
         end
         if (r == pulse_r) begin
            start = 1'b1;
            key   = SEQ_KEY;
         end
         checkOutput("beat_valid", 128'(rk_valid), 128'd1);
         checkOutput("beat_busy",  128'(busy),     128'd1);
         checkOutput("beat_round", 128'(rk_round), 128'(r));
         checkOutput("beat_last",  128'(rk_last),  128'(r == 0));
         if (dmask[r]) checkOutput("beat_data", rk_data, expv(r));
         @(posedge clk); #1;
         start = 1'b0;
      end
      checkOutput("done_busy",  128'(busy),     128'd0);
      checkOutput("done_valid", 128'(rk_valid), 128'd0);
   endtask

   task automatic loadFips();
      for (int i = 0; i <= 10; i++) exp_rk[i] = fips_rk[i];
   endtask

   initial begin
      fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
      fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
      fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
      fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
      fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
      fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
      fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
      fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
      fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
      fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

      rst      = 1'b1;
      start    = 1'b0;
      key      = '0;
      rk_ready = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checkZeros("reset");
      rst = 1'b0;

      $display("[TB] FIPS key, ready held high");
      rk_ready = 1'b1;
      loadFips();
      applyStimulus(FIPS_KEY);
      waitValid(0);
      collectBeats(11'h7ff, 1'b0, -1, -1);

      $display("[TB] sequential key, started in the cycle busy drops");
      exp_rk[10] = SEQ_R10;
      exp_rk[0]  = SEQ_KEY;
      applyStimulus(SEQ_KEY);
      waitValid(0);
      collectBeats(11'h401, 1'b0, -1, -1);

      $display("[TB] FIPS key with random ready stalls");
      loadFips();
      applyStimulus(FIPS_KEY);
      waitValid(0);
      collectBeats(11'h7ff, 1'b1, -1, -1);
      rk_ready = 1'b1;

      $display("[TB] start pulses during EXPAND and OUTPUT are ignored");
      applyStimulus(FIPS_KEY);
      @(posedge clk); #1;
      @(posedge clk); #1;
      start = 1'b1;
      key   = SEQ_KEY;
      @(posedge clk); #1;
      start = 1'b0;
      waitValid(3);
      collectBeats(11'h7ff, 1'b0, 7, -1);

      $display("[TB] reset mid-EXPAND and mid-OUTPUT");
      applyStimulus(FIPS_KEY);
      repeat (4) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checkZeros("rst_expand");
      @(posedge clk); #1;
      checkOutput("rst_expand_stays_idle", 128'(busy), 128'd0);
      applyStimulus(FIPS_KEY);
      waitValid(0);
      collectBeats(11'h7ff, 1'b0, -1, 4);
      @(posedge clk); #1;
      checkOutput("rst_output_stays_idle", 128'(busy), 128'd0);
      applyStimulus(FIPS_KEY);
      waitValid(0);
      collectBeats(11'h7ff, 1'b0, -1, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
